lifo_stack: RTL and testbench

//  Synchronous LIFO stack used twice beside the cpu: operand stack (stack_*_operations) and

---
 rtl/lifo_stack_pkg.sv | 49 ++++
 rtl/lifo_stack_ram.sv | 30 +++
 rtl/lifo_stack.sv | 120 ++++++++++++
 tb/tb_lifo_stack.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/lifo_stack_pkg.sv
// lifo_stack_pkg
//   Shared defaults for the cpu's operand and subroutine stacks, the FSM state
//   encodings, and the strobe decoder used by lifo_stack.
package lifo_stack_pkg;

    // Data width and stack depths shared by the cpu and both stack instances
    localparam int WIDTH_DATA_DEF = 16;
    localparam int DEPTH_OPS_DEF  = 16;  // operand stack
    localparam int DEPTH_SUB_DEF  = 16;  // subroutine return stack

    // Last-operation tracker; kept as plain constants for legacy tools
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PUSH = 3'd1;
    localparam logic [2:0] S_POP  = 3'd2;
    localparam logic [2:0] S_SWAP = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    // One cycle's decoded intent after the full/empty guards
    typedef struct packed {
        logic do_push;  // write at count, count+1
        logic do_pop;   // read top, count-1
        logic swap;     // read old top and overwrite it, count unchanged
        logic ovf;      // push refused because full
        logic unf;      // pop refused because empty
    } stack_op_t;

    function automatic stack_op_t decode_op(input logic push, input logic pop,
                                            input logic full, input logic empty);
        stack_op_t op;
        op = '0;
        if (push && pop) begin
            // Swap is legal even when full; on empty only the push survives
            if (empty) begin
                op.do_push = 1'b1;
                op.unf     = 1'b1;
            end else begin
                op.swap    = 1'b1;
            end
        end else if (push) begin
            if (full) op.ovf     = 1'b1;
            else      op.do_push = 1'b1;
        end else if (pop) begin
            if (empty) op.unf    = 1'b1;
            else       op.do_pop = 1'b1;
        end
        return op;
    endfunction

endpackage

// File: rtl/lifo_stack_ram.sv
// lifo_stack_ram
//   DEPTH x WIDTH_DATA register array, no reset.
//   clk     : write clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write word
//   raddr_i : asynchronous read index
//   rdata_o : word at raddr_i (combinational)
module lifo_stack_ram #(
    parameter int WIDTH_DATA = 16,
    parameter int DEPTH      = 16,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [PTR_W-1:0]      waddr_i,
    input  logic [WIDTH_DATA-1:0] wdata_i,
    input  logic [PTR_W-1:0]      raddr_i,
    output logic [WIDTH_DATA-1:0] rdata_o
);

    logic [WIDTH_DATA-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lifo_stack.sv
// lifo_stack
//   Synchronous LIFO with registered top-of-stack read, occupancy, and sticky
//   overflow/underflow flags. Used as both the cpu operand stack and the
//   subroutine return stack.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   push/pop  : level-sampled strobes, one operation per edge
//   data_in   : word to push
//   data_out  : registered popped word, valid the cycle after pop
//   full/empty: combinational from count
//   count     : occupancy 0..DEPTH
//   overflow  : sticky, push while full (without pop)
//   underflow : sticky, pop while empty
//   clear_err : synchronous clear of both flags; a same-cycle error wins
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int WIDTH_DATA = WIDTH_DATA_DEF,
    parameter int DEPTH      = DEPTH_OPS_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH_DATA-1:0]    data_in,
    output logic [WIDTH_DATA-1:0]    data_out,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clear_err
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]        count_q, count_d;
    logic [WIDTH_DATA-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [2:0]            state_q, state_d;

    stack_op_t             op;
    logic [PTR_W-1:0]      top_idx;
    logic                  we;
    logic [PTR_W-1:0]      waddr;
    logic [WIDTH_DATA-1:0] rdata;

    assign full  = (count_q == DEPTH[PTR_W:0]);
    assign empty = (count_q == '0);

    assign op = decode_op(push, pop, full, empty);

    // Index of the current top; when full the low bits are 0 and wrap to DEPTH-1
    assign top_idx = count_q[PTR_W-1:0] - 1'b1;

    // A swap overwrites the old top in place after it has been read out
    assign we    = op.do_push | op.swap;
    assign waddr = op.swap ? top_idx : count_q[PTR_W-1:0];

    lifo_stack_ram #(
        .WIDTH_DATA (WIDTH_DATA),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (data_in),
        .raddr_i (top_idx),
        .rdata_o (rdata)
    );

    always_comb begin
        count_d = count_q;
        if (op.do_push) count_d = count_q + 1'b1;
        if (op.do_pop)  count_d = count_q - 1'b1;

        dout_d = (op.do_pop | op.swap) ? rdata : dout_q;

        ovf_d = op.ovf | (ovf_q & ~clear_err);
        unf_d = op.unf | (unf_q & ~clear_err);

        // Every state re-branches from the current strobes, so one decode covers all
        state_d = S_IDLE;
        if (op.ovf | op.unf)  state_d = S_ERR;
        else if (op.swap)     state_d = S_SWAP;
        else if (op.do_push)  state_d = S_PUSH;
        else if (op.do_pop)   state_d = S_POP;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            state_q <= S_IDLE;
        end else begin
            count_q <= count_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            state_q <= state_d;
        end
    end

    assign data_out  = dout_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    // An error cycle always leaves a flag raised, even if clear_err was asserted
    a_err_flag : assert property (@(posedge clk) disable iff (!reset)
        (state_q == S_ERR) |-> (ovf_q || unf_q));

    a_count_range : assert property (@(posedge clk) disable iff (!reset)
        count_q <= DEPTH[PTR_W:0]);

endmodule

// File: tb/tb_lifo_stack.sv
module tb_lifo_stack;

    localparam int W     = 16;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         push = 1'b0, pop = 1'b0, clear_err = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [W-1:0] data_out;
    logic         full, empty, overflow, underflow;
    logic [4:0]   count;

    lifo_stack #(.WIDTH_DATA(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .clear_err (clear_err)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stack contents, expected-output scoreboard, flags
    logic [W-1:0] mdl[$];
    logic [W-1:0] sb[$];
    logic [W-1:0] m_do  = '0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("dout",  32'(data_out),  32'(m_do));
        chk("count", 32'(count),     32'(mdl.size()));
        chk("full",  32'(full),      32'(mdl.size() == DEPTH));
        chk("empty", 32'(empty),     32'(mdl.size() == 0));
        chk("ovf",   32'(overflow),  32'(m_ovf));
        chk("unf",   32'(underflow), 32'(m_unf));
    endtask

    // One clock of stimulus; the model predicts the result, then outputs are checked
    task automatic step(input logic ps, input logic pp, input logic [W-1:0] din, input logic clr);
        logic ev_o, ev_u;
        ev_o = 1'b0;
        ev_u = 1'b0;
        push = ps; pop = pp; data_in = din; clear_err = clr;
        if (ps && pp) begin
            if (mdl.size() > 0) begin
                sb.push_back(mdl[mdl.size()-1]);
                mdl[mdl.size()-1] = din;
            end else begin
                mdl.push_back(din);
                ev_u = 1'b1;
            end
        end else if (ps) begin
            if (mdl.size() < DEPTH) mdl.push_back(din);
            else ev_o = 1'b1;
        end else if (pp) begin
            if (mdl.size() > 0) sb.push_back(mdl.pop_back());
            else ev_u = 1'b1;
        end
        m_ovf = ev_o | (m_ovf & ~clr);
        m_unf = ev_u | (m_unf & ~clr);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clear_err = 1'b0;
        if (sb.size() > 0) m_do = sb.pop_front();
        check_all();
    endtask

    initial begin
        // 1) Reset, then a reset landing in the middle of a push
        #12 reset = 1'b1;
        #1 check_all();
        step(1, 0, 16'h1234, 0);
        step(1, 0, 16'h5678, 0);
        step(1, 0, 16'h0000, 0);  // empty-flag/pop traffic before the abort
        step(0, 1, 16'h0000, 0);
        push = 1'b1; data_in = 16'hBEEF;
        #2 reset = 1'b0;
        #1;
        mdl.delete(); sb.delete();
        m_do = '0; m_ovf = 1'b0; m_unf = 1'b0;
        check_all();
        @(negedge clk);
        push = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1 check_all();

        // 2) Three pushes, three pops in reverse order
        step(1, 0, 16'h0011, 0);
        step(1, 0, 16'h0022, 0);
        step(1, 0, 16'h0033, 0);
        step(0, 1, 16'h0000, 0);
        chk("pop1", 32'(data_out), 32'h0033);
        step(0, 1, 16'h0000, 0);
        chk("pop2", 32'(data_out), 32'h0022);
        step(0, 1, 16'h0000, 0);
        chk("pop3", 32'(data_out), 32'h0011);
        chk("empty_end", 32'(empty), 32'd1);

        // 3) Fill to DEPTH, refused 17th push, drain
        for (int i = 0; i < DEPTH; i++) step(1, 0, 16'h0100 + 16'(i), 0);
        chk("full16", 32'(full), 32'd1);
        step(1, 0, 16'hDEAD, 0);
        chk("ovf17", 32'(overflow), 32'd1);
        chk("cnt17", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 16'h0000, 0);
            chk("no_dead", 32'(data_out == 16'hDEAD), 32'd0);
        end
        step(0, 0, 16'h0000, 1);

        // 4) Underflow on empty, data_out held, then clear
        step(0, 1, 16'h0000, 0);
        chk("unf_set", 32'(underflow), 32'd1);
        chk("unf_hold", 32'(data_out), 32'h0100);
        step(0, 0, 16'h0000, 1);
        chk("unf_clr", 32'(underflow), 32'd0);
        // error in the same cycle as clear_err wins
        step(0, 1, 16'h0000, 1);
        chk("err_wins", 32'(underflow), 32'd1);
        step(0, 0, 16'h0000, 1);

        // 5) Swap on a one-entry stack, then on a full stack
        step(1, 0, 16'h0005, 0);
        step(1, 1, 16'h0009, 0);
        chk("swap_do", 32'(data_out), 32'h0005);
        chk("swap_cnt", 32'(count), 32'd1);
        step(0, 1, 16'h0000, 0);
        chk("swap_pop", 32'(data_out), 32'h0009);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 16'(($urandom_range(0, 16'hFFFF))), 0);
        step(1, 1, 16'h0AAA, 0);
        chk("swap_full_ovf", 32'(overflow), 32'd0);
        step(0, 1, 16'h0000, 0);
        chk("swap_full_pop", 32'(data_out), 32'h0AAA);
        while (mdl.size() > 0) step(0, 1, 16'h0000, 0);

        // 6) Push+pop on empty: push lands, pop flagged
        step(1, 1, 16'h0007, 0);
        chk("pp_empty_cnt", 32'(count), 32'd1);
        chk("pp_empty_unf", 32'(underflow), 32'd1);
        step(0, 1, 16'h0000, 0);
        chk("pp_empty_pop", 32'(data_out), 32'h0007);

        // Random mix against the model
        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 7) == 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
